// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB,
    LOCKED
  } arb_state_t;

  localparam int unsigned DEFAULT_ADDR_W   = 8;
  localparam int unsigned DEFAULT_DATA_W   = 16;
  localparam int unsigned DEFAULT_MAX_LOCK = 8;

  function automatic int unsigned lock_cnt_width(int unsigned max_lock);
    return $clog2(max_lock + 1);
  endfunction

  localparam int unsigned LOCK_CNT_W = lock_cnt_width(DEFAULT_MAX_LOCK);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int unsigned cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one 1R/1W data memory, with a bounded lock mode for RMW.
// Optional per-requester grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned MAX_LOCK = DEFAULT_MAX_LOCK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_wt_en,
  output logic [ADDR_W-1:0]         mem_wt_addr,
  output logic [DATA_W-1:0]         mem_data_wt,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_W-1:0]         mem_read_out,
  output logic [NUM_REQ*16-1:0]     grant_cnt
);

  localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LockCntW = lock_cnt_width(MAX_LOCK);
  localparam logic [LockCntW-1:0] LockMax = LockCntW'(MAX_LOCK);
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;

  logic                gnt_vld;
  logic [IdxW-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic                gnt_we;
  logic                gnt_lock;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic                owner_valid;
  logic                owner_lock;
  logic                rd_gnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_picker (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_valid = req_valid[owner_q];
  assign owner_lock  = req_lock[owner_q];

  // Grant decision; suppressed while in reset so nothing reaches the memory.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = owner_q;
    gnt_onehot = '0;
    unique case (state_q)
      ARB: begin
        gnt_vld    = pick_any;
        gnt_idx    = pick_idx;
        gnt_onehot = pick_gnt;
      end
      LOCKED: begin
        if (owner_valid && (!owner_lock || (lock_cnt_q < LockMax))) begin
          gnt_vld             = 1'b1;
          gnt_onehot[owner_q] = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      gnt_vld    = 1'b0;
      gnt_onehot = '0;
    end
  end

  assign gnt_we    = req_we[gnt_idx];
  assign gnt_lock  = req_lock[gnt_idx];
  assign gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign gnt_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign rd_gnt    = gnt_vld & ~gnt_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ARB: begin
        if (gnt_vld) begin
          rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
          if (gnt_lock) begin
            state_d    = LOCKED;
            owner_d    = gnt_idx;
            lock_cnt_d = LockCntW'(1);
          end
        end
      end
      LOCKED: begin
        if (owner_valid) begin
          if (!owner_lock || (lock_cnt_q == LockMax)) begin
            // Final unlocked access, or forced release at the lock budget.
            state_d    = ARB;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else if (!owner_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    req_ready   = gnt_onehot;
    mem_wt_en   = gnt_vld & gnt_we;
    mem_wt_addr = mem_wt_en ? gnt_addr : '0;
    mem_data_wt = mem_wt_en ? gnt_wdata : '0;
    mem_rd_addr = rd_gnt ? gnt_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_gnt ? gnt_onehot : '0;
      if (rd_gnt) rsp_rdata_q <= mem_read_out;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_onehot[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized and directed bench for mem_access_arbiter against a behavioural model.
module tb_mem_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ML = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we    = '0;
  logic [N-1:0]    req_lock  = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_wt_en;
  logic [AW-1:0]   mem_wt_addr;
  logic [DW-1:0]   mem_data_wt;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_read_out;
  logic [N*16-1:0] grant_cnt;

  mem_access_arbiter #(
    .NUM_REQ  (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_LOCK (ML)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_wt_en    (mem_wt_en),
    .mem_wt_addr  (mem_wt_addr),
    .mem_data_wt  (mem_data_wt),
    .mem_rd_addr  (mem_rd_addr),
    .mem_read_out (mem_read_out),
    .grant_cnt    (grant_cnt)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT, with a backdoor port used only for preloading.
  logic [DW-1:0] mem [256];
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (mem_wt_en) mem[mem_wt_addr] <= mem_data_wt;
  end
  assign mem_read_out = mem[mem_rd_addr];

  // Reference model
  logic [DW-1:0] ref_mem [256];
  bit            m_locked;
  int            m_rr, m_owner, m_cnt;
  logic [N-1:0]  m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  int            m_stat [N];
  int            last_gnt = -1;

  int checks   = 0;
  int failures = 0;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 16) return 16'hBEEF;
    return 16'((i * 40503) ^ 16'h3C5A);
  endfunction

  function automatic logic [AW-1:0] get_addr(int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] get_wdata(int i);
    return req_wdata[i*DW +: DW];
  endfunction

  // Who should be served right now, from the arbitration rules.
  function automatic int exp_grant();
    int i;
    if (!rst_n) return -1;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (req_valid[i]) return i;
      end
      return -1;
    end
    if (req_valid[m_owner] && (!req_lock[m_owner] || m_cnt < ML)) return m_owner;
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked    = 1'b0;
    m_rr        = 0;
    m_owner     = 0;
    m_cnt       = 0;
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
    last_gnt = -1;
  endtask

  task automatic sample_and_check();
    int g;
    logic [N-1:0]    e_rdy;
    logic            e_we;
    logic [AW-1:0]   e_wa, e_ra;
    logic [DW-1:0]   e_wd;
    logic [N*16-1:0] e_cnt;
    @(negedge clk);
    g     = exp_grant();
    e_rdy = '0;
    e_we  = 1'b0;
    e_wa  = '0;
    e_ra  = '0;
    e_wd  = '0;
    if (g >= 0) begin
      e_rdy[g] = 1'b1;
      if (req_we[g]) begin
        e_we = 1'b1;
        e_wa = get_addr(g);
        e_wd = get_wdata(g);
      end else begin
        e_ra = get_addr(g);
      end
    end
    e_cnt = '0;
`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_cnt[i*16 +: 16] = 16'(m_stat[i]);
`endif
    chk("req_ready", req_ready, e_rdy);
    chk("mem_wt_en", mem_wt_en, e_we);
    chk("mem_wt_addr", mem_wt_addr, e_wa);
    chk("mem_data_wt", mem_data_wt, e_wd);
    chk("mem_rd_addr", mem_rd_addr, e_ra);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_rdata", rsp_rdata, m_rsp_data);
    chk("grant_cnt", grant_cnt, e_cnt);
  endtask

  // Apply the coming clock edge to the model, then move to just after that edge.
  task automatic advance();
    int g;
    int o;
    g = exp_grant();
    m_rsp_valid = '0;
    if (g >= 0) begin
      if (req_we[g]) begin
        ref_mem[get_addr(g)] = get_wdata(g);
      end else begin
        m_rsp_valid[g] = 1'b1;
        m_rsp_data     = ref_mem[get_addr(g)];
      end
      if (m_stat[g] < 65535) m_stat[g]++;
    end
    if (!m_locked) begin
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (req_lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_cnt    = 1;
        end
      end
    end else begin
      o = m_owner;
      if (req_valid[o]) begin
        if (!req_lock[o]) m_locked = 1'b0;
        else if (m_cnt < ML) m_cnt++;
        else m_locked = 1'b0;
      end else if (!req_lock[o]) begin
        m_locked = 1'b0;
      end
    end
    last_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample_and_check();
    advance();
  endtask

  task automatic do_reset(bit init);
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    if (init) begin
      for (int i = 0; i < 256; i++) begin
        bk_we      = 1'b1;
        bk_addr    = 8'(i);
        bk_data    = init_val(i);
        ref_mem[i] = init_val(i);
        @(posedge clk);
        #1;
      end
    end
    bk_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_rdata", rsp_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit v, bit we, bit lk, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i]            = v;
    req_we[i]               = we;
    req_lock[i]             = lk;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic random_phase(int n);
    bit pending;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        pending = req_valid[i] && (last_gnt != i);
        if (pending) begin
          // Stalled requests hold their fields, occasionally withdraw.
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else begin
          set_req(i, $urandom_range(3) != 0, 1'($urandom_range(1)),
                  $urandom_range(3) == 0, 8'($urandom_range(15)), 16'($urandom));
        end
      end
      cycle();
    end
  endtask

  logic [N-1:0] rr_rdy [4];
  logic [N-1:0] rr_rsp [4];
  logic [N-1:0] fr_rdy [12];

  initial begin
    rr_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    rr_rsp = '{2'b00, 2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 12; k++) fr_rdy[k] = (k < 8) ? 2'b01 : (k == 8) ? 2'b00 :
                                             (k == 9) ? 2'b10 : 2'b01;
    model_reset();
    do_reset(1'b1);

    // Idle after reset
    sample_and_check();
    chk("idle_ready", req_ready, 2'b00);
    chk("idle_wt_en", mem_wt_en, 1'b0);
    advance();

    // Single read of preloaded 0x10
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
    sample_and_check();
    chk("single_ready", req_ready, 2'b01);
    chk("single_rd_addr", mem_rd_addr, 8'h10);
    advance();
    req_valid = '0;
    sample_and_check();
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_rdata", rsp_rdata, 16'hBEEF);
    advance();

    // Round-robin between two readers from reset
    do_reset(1'b0);
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h11, 16'h0);
    for (int k = 0; k < 4; k++) begin
      sample_and_check();
      chk("rr_ready", req_ready, rr_rdy[k]);
      chk("rr_rsp_valid", rsp_valid, rr_rsp[k]);
      advance();
    end
    req_valid = '0;
    sample_and_check();
    chk("rr_last_rsp", rsp_valid, 2'b10);
    advance();

    // Write then read the same address
    set_req(1, 1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234);
    sample_and_check();
    chk("wr_ready", req_ready, 2'b10);
    chk("wr_en", mem_wt_en, 1'b1);
    chk("wr_addr", mem_wt_addr, 8'hFF);
    chk("wr_data", mem_data_wt, 16'h1234);
    advance();
    req_valid = '0;
    set_req(0, 1'b1, 1'b0, 1'b0, 8'hFF, 16'h0);
    sample_and_check();
    chk("raw_ready", req_ready, 2'b01);
    advance();
    req_valid = '0;
    sample_and_check();
    chk("raw_rdata", rsp_rdata, 16'h1234);
    chk("raw_rsp_valid", rsp_valid, 2'b01);
    advance();

    // Locked read-modify-write by requester 1 while requester 0 waits
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h30, 16'h0);
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h20, 16'h0);
    sample_and_check();
    chk("rmw_rd_ready", req_ready, 2'b10);
    advance();
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h20, 16'h5678);
    sample_and_check();
    chk("rmw_wr_ready", req_ready, 2'b10);
    advance();
    req_valid[1] = 1'b0;
    sample_and_check();
    chk("rmw_after_ready", req_ready, 2'b01);
    advance();
    req_valid = '0;
    cycle();

    // Forced release after MAX_LOCK grants
    do_reset(1'b0);
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h40, 16'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h41, 16'h0);
    for (int k = 0; k < 12; k++) begin
      sample_and_check();
      chk("force_ready", req_ready, fr_rdy[k]);
      advance();
    end
    req_valid = '0;
    req_lock  = '0;
    cycle();

    // Asynchronous reset with a read response pending and a write requested
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
    cycle();
    chk("pend_rsp_valid", rsp_valid, 2'b01);
    req_valid = '0;
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h55, 16'hAAAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid, 2'b00);
    chk("async_rsp_rdata", rsp_rdata, 16'h0000);
    chk("async_ready", req_ready, 2'b00);
    chk("async_wt_en", mem_wt_en, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h55, 16'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
    sample_and_check();
    chk("post_reset_ready", req_ready, 2'b01);
    advance();
    req_valid = '0;
    sample_and_check();
    chk("no_commit_in_reset", rsp_rdata, init_val(8'h55));
    advance();

    random_phase(3000);

    req_valid = '0;
    req_lock  = '0;
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-write/single-read 256x16 data memory between NUM_REQ requesters, e.g. pipeline MEM stage, debug loader and DMA.
- One access per cycle, chosen round-robin. Writes commit on the grant edge. Read data returns registered one cycle later.
- A lock mode gives one requester back-to-back exclusive grants for read-modify-write sequences.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory data width.
- MAX_LOCK, 8, maximum consecutive grants while locked before forced release.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  request or hold exclusive ownership.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_ready  out  NUM_REQ  one-hot grant, combinational; transfer when valid & ready.
- rsp_valid  out  NUM_REQ  one-cycle pulse for the read-data owner.
- rsp_rdata  out  DATA_W  registered read data.
- mem_wt_en  out  1  memory write enable.
- mem_wt_addr  out  ADDR_W  memory write address.
- mem_data_wt  out  DATA_W  memory write data.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_read_out  in  DATA_W  combinational memory read data.
- grant_cnt  out  NUM_REQ*16  per-requester grant counters; only active under the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ARB, rr_ptr = 0, owner = 0, lock_cnt = 0.
  - rsp_valid = 0, rsp_rdata = 0, grant_cnt = 0.
  - mem_wt_en is 0 because no grant exists.
- Reset mid-operation: a write whose edge coincides with rst_n low does not commit. A pending rsp_valid is dropped.
- ARB state:
  - Grant goes to the first requester with req_valid = 1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one req_ready bit is high, and only for a valid requester. req_ready never asserts without req_valid.
  - On a grant to requester g: rr_ptr <= (g+1) mod NUM_REQ.
  - If req_lock[g] = 1 on the grant: state <= LOCKED, owner <= g, lock_cnt <= 1.
- LOCKED state:
  - Only the owner is eligible. Other requesters see req_ready = 0 and stall.
  - Owner valid with req_lock = 1 and lock_cnt < MAX_LOCK: grant, lock_cnt++.
  - Owner valid with req_lock = 0: grant this final access, then state <= ARB.
  - Owner not valid with req_lock = 0: state <= ARB. No grant this cycle.
  - lock_cnt == MAX_LOCK while owner still valid: no grant, state <= ARB (forced release). rr_ptr is already past the owner.
  - Owner idle with req_lock = 1: hold LOCKED, no grant, lock_cnt unchanged.
- Memory drive, combinational from the grant:
  - Grant g write: mem_wt_en = 1, mem_wt_addr = addr[g], mem_data_wt = wdata[g].
  - Grant g read: mem_rd_addr = addr[g], mem_wt_en = 0.
  - No grant: all address/data outputs are 0 and mem_wt_en = 0.
- Read latency: one cycle.
  - At the grant edge: rsp_rdata <= mem_read_out, rsp_valid <= onehot(g).
  - rsp_valid clears the next cycle unless another read is granted.
  - rsp_rdata holds its value between reads.
  - Write grants produce no response.
- Read-after-write: a write granted in cycle N followed by a read of the same address in cycle N+1 returns the new data. Only one access occurs per cycle, so there are no same-cycle conflicts.
- Back-to-back: the same requester may be granted on consecutive cycles only if no other requester is valid, or while locked.
- Input rules:
  - Requesters must hold addr, wdata, we and lock stable while valid and not ready.
  - Dropping valid before ready is allowed (request withdrawn).

Optional Feature:
- MEM_ARB_STATS_EN defined: grant_cnt[i] increments on each grant to requester i and saturates at 0xFFFF. It is cleared by reset.
- MEM_ARB_STATS_EN undefined: grant_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {ARB, LOCKED}.
  - Default ADDR_W/DATA_W constants.
  - LOCK_CNT_W constant = $clog2(MAX_LOCK+1).
- Sub-module rr_picker: purely combinational. Inputs: request vector and rr_ptr. Outputs: one-hot grant and index.
- Lock FSM, response register and counters stay in the top module.

Test Plan:
- Single read: preload mem[0x10] = 0xBEEF; requester 0 reads 0x10 → req_ready[0] same cycle; next cycle rsp_valid = 01, rsp_rdata = 0xBEEF.
- Round-robin: both requesters hold valid (reads) for 4 cycles from reset → grants 0,1,0,1; rsp_valid pulses alternate 01,10,01,10.
- Write then read: requester 1 writes 0x1234 to 0xFF; requester 0 reads 0xFF next cycle → rsp_rdata = 0x1234.
- Lock RMW: requester 1 locks, reads 0x20, then writes 0x20 with lock = 0, while requester 0 is valid throughout → requester 0 sees ready = 0 for both cycles and is granted on the third cycle.
- Forced release: MAX_LOCK = 8; requester 0 holds valid & lock for 12 cycles while requester 1 is valid → 8 grants to 0, then one idle cycle, then grant to 1.
- Async reset during a pending read: rst_n low mid-cycle → rsp_valid = 0 and rsp_rdata = 0 immediately; after release, first grant goes to requester 0 (rr_ptr = 0).
